mux_n_skid: RTL



---
 rtl/mux_n_skid.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mux_n_skid.sv
// mux_n_skid: N:1 data select feeding a two-entry skid buffer with valid/ready flow control.
// The head entry (main register) drives the outputs; the skid register absorbs one extra beat
// after out_ready drops, so in_ready decodes only the state register.
// Optional feature: define MUX_N_SKID_SEL_ERR_EN to enable the sticky sel_err flag.
module mux_n_skid #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic [WIDTH-1:0] sel_word;
    logic             sel_oob;
    logic             accept;
    logic             pop;

    // Pick the addressed input; selects at or beyond NUM_IN read as all-zero
    always_comb begin
        sel_word = '0;
        sel_oob  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
                sel_oob  = 1'b0;
            end
        end
    end

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;

    // Next-state and entry loads; registers only change on accept or pop
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StOne;
                    main_data_d = sel_word;
                    main_sel_d  = in_sel;
                end
            end
            StOne: begin
                if (accept && !pop) begin
                    state_d     = StFull;
                    skid_data_d = sel_word;
                    skid_sel_d  = in_sel;
                end else if (pop && !accept) begin
                    state_d = StEmpty;
                end else if (accept && pop) begin
                    main_data_d = sel_word;
                    main_sel_d  = in_sel;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d     = StOne;
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // State and entry registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end

`ifdef MUX_N_SKID_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    // Sticky flag: set by any accepted out-of-range select, cleared only by reset
    always_comb begin
        sel_err_d = sel_err_q | (accept & sel_oob);
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    logic unused_sel_oob;
    assign unused_sel_oob = sel_oob;
    assign sel_err        = 1'b0;
`endif

endmodule
